placement_unloader: RTL and testbench

Post-placement readback engine. After the placement engine has filled the grid RAM (cell value = node id, −1 = empty) and the per-node pos_X/pos_Y RAMs, this block scans the grid in row-major order and streams every occupied cell out as a (node, x, y) beat over a valid/ready interface. Optionally it cross-checks each cell against the node's stored position and flags inconsistencies. It is the read-side counterpart of the placer, feeding result dump, host transfer and later routing stages.

---
 rtl/placement_unloader.sv | 160 ++++++++++++++++
 tb/tb_placement_unloader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/placement_unloader.sv
// placement_unloader: scans the placement grid row-major and streams each occupied cell as a (node,x,y) beat.
// Latency: 3 cycles per empty cell; 4 per occupied cell (7 with PLACE_CHECK_EN) plus stall cycles.
// Backpressure: in EMIT the beat is held stable and the scan pauses until out_ready is seen at a rising edge.
// Build option: define PLACE_CHECK_EN to cross-check each cell against the node's pos_X/pos_Y entries.
module placement_unloader #(
  parameter int N  = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          reGrid,
  output logic [DW-1:0] addrGrid,
  input  logic [DW-1:0] doutGrid,
  output logic          rePX,
  output logic          rePY,
  output logic [DW-1:0] addrPos,
  input  logic [DW-1:0] doutPX,
  input  logic [DW-1:0] doutPY,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_node,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y,
  output logic [DW-1:0] count,
  output logic          mismatch
);

  typedef enum logic [3:0] {
    IDLE, GRD_RD, GRD_WAIT, GRD_CAP, POS_RD, POS_WAIT, POS_CAP, EMIT, DONE
  } state_t;

  localparam logic [DW-1:0] LAST  = DW'(N - 1);
  localparam logic [DW-1:0] EMPTY = '1;   // -1 marks an unoccupied cell
  localparam logic [DW-1:0] ONE   = DW'(1);

  state_t state, next_state;

  // Scan position; addrGrid doubles as the linear cell index x*N+y
  logic [DW-1:0] x, y;
  logic          rePos;
  logic          mism_q;

  logic cell_empty, last_cell, start_acc, advance, pos_bad;
  logic reGrid_d, rePos_d, out_valid_d, busy_d, done_d;

  assign cell_empty = (doutGrid == EMPTY);
  assign last_cell  = (x == LAST) && (y == LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = GRD_RD;
      GRD_RD:   next_state = GRD_WAIT;
      GRD_WAIT: next_state = GRD_CAP;
      GRD_CAP: begin
        if (cell_empty) next_state = last_cell ? DONE : GRD_RD;
`ifdef PLACE_CHECK_EN
        else            next_state = POS_RD;
`else
        else            next_state = EMIT;
`endif
      end
      POS_RD:   next_state = POS_WAIT;
      POS_WAIT: next_state = POS_CAP;
      POS_CAP:  next_state = EMIT;
      EMIT:     if (out_ready) next_state = last_cell ? DONE : GRD_RD;
      DONE:     if (start) next_state = GRD_RD;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode: strobes and valid line up with their states; busy/done follow the state by one cycle
  always_comb begin
    start_acc   = ((state == IDLE) || (state == DONE)) && start;
    advance     = ((state == GRD_CAP) && cell_empty) || ((state == EMIT) && out_ready);
    reGrid_d    = (next_state == GRD_RD);
    rePos_d     = (next_state == POS_RD);
    out_valid_d = (next_state == EMIT);
    busy_d      = (state != IDLE) && (state != DONE);
    done_d      = (state == DONE) && !start;
  end

`ifdef PLACE_CHECK_EN
  assign pos_bad  = (state == POS_CAP) && ((doutPX != x) || (doutPY != y));
  assign rePX     = rePos;
  assign rePY     = rePos;
  assign addrPos  = out_node;
  assign mismatch = mism_q;
`else
  logic unused_pos;
  assign unused_pos = ^{doutPX, doutPY, rePos, mism_q};
  assign pos_bad    = 1'b0;
  assign rePX       = 1'b0;
  assign rePY       = 1'b0;
  assign addrPos    = '0;
  assign mismatch   = 1'b0;
`endif

  // Registered outputs and scan datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      reGrid    <= 1'b0;
      rePos     <= 1'b0;
      out_valid <= 1'b0;
      addrGrid  <= '0;
      out_node  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      count     <= '0;
      mism_q    <= 1'b0;
      x         <= '0;
      y         <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      reGrid    <= reGrid_d;
      rePos     <= rePos_d;
      out_valid <= out_valid_d;
      if (start_acc) begin
        x        <= '0;
        y        <= '0;
        addrGrid <= '0;
        count    <= '0;
        mism_q   <= 1'b0;
      end else begin
        // Step to the next cell; at the final cell x/y are left as-is until the next start
        if (advance && !last_cell) begin
          addrGrid <= addrGrid + ONE;
          if (y == LAST) begin
            y <= '0;
            x <= x + ONE;
          end else begin
            y <= y + ONE;
          end
        end
        // Latch the beat once per occupied cell so it stays stable through EMIT
        if ((state == GRD_CAP) && !cell_empty) begin
          out_node <= doutGrid;
          out_x    <= x;
          out_y    <= y;
        end
        if ((state == EMIT) && out_ready) count <= count + ONE;
        if (pos_bad) mism_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_placement_unloader.sv
// tb_placement_unloader: randomized scans of a modelled grid/position memory checked against a reference beat list.
// Covers reset values, empty-grid timing, backpressure hold, position cross-check, mid-scan reset and ignored restarts.
// Build with PLACE_CHECK_EN defined to exercise the cross-check path; expectations follow the same macro.
module tb_placement_unloader;

  localparam int N    = 10;
  localparam int DW   = 32;
  localparam int NPOS = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, reGrid, rePX, rePY, out_valid, mismatch;
  logic          out_ready = 1'b0;
  logic [DW-1:0] addrGrid, addrPos, out_node, out_x, out_y, count;
  logic [DW-1:0] doutGrid = '0, doutPX = '0, doutPY = '0;

  int grid_mem [N*N];
  int px_mem   [NPOS];
  int py_mem   [NPOS];

  int checks = 0;
  int errors = 0;

  placement_unloader #(.N(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
    .rePX(rePX), .rePY(rePY), .addrPos(addrPos), .doutPX(doutPX), .doutPY(doutPY),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_node(out_node), .out_x(out_x), .out_y(out_y),
    .count(count), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  function automatic int rd_px(input logic [DW-1:0] a);
    if (a < NPOS) return px_mem[a];
    return 32'h7fff_0000;
  endfunction

  function automatic int rd_py(input logic [DW-1:0] a);
    if (a < NPOS) return py_mem[a];
    return 32'h7fff_0001;
  endfunction

  // Synchronous-read memories: data appears after the edge that samples the strobe and is held
  always @(posedge clk) begin
    if (reGrid) doutGrid <= (addrGrid < N*N) ? grid_mem[addrGrid] : 32'hdead_beef;
    if (rePX)   doutPX   <= rd_px(addrPos);
    if (rePY)   doutPY   <= rd_py(addrPos);
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < N*N; a++) grid_mem[a] = -1;
    for (int i = 0; i < NPOS; i++) begin
      px_mem[i] = 1000 + i;
      py_mem[i] = 2000 + i;
    end
  endtask

  task automatic place(input int xx, input int yy, input int node);
    grid_mem[xx*N + yy] = node;
    if (node >= 0 && node < NPOS) begin
      px_mem[node] = xx;
      py_mem[node] = yy;
    end
  endtask

  task automatic random_fill();
    int node;
    clear_mem();
    for (int a = 0; a < N*N; a++) begin
      if ($urandom_range(0, 9) < 3) begin
        node = ($urandom_range(0, 15) == 0) ? -7 : int'($urandom_range(0, NPOS-1));
        place(a / N, a % N, node);
        if (node >= 0 && $urandom_range(0, 9) == 0) px_mem[node] = 99;
      end
    end
  endtask

  // Reference: every non-empty cell in row-major order; inconsistency if stored position differs
  function automatic bit model_mismatch();
    bit m = 1'b0;
    for (int a = 0; a < N*N; a++)
      if (grid_mem[a] != -1)
        if (rd_px(32'(grid_mem[a])) != a / N || rd_py(32'(grid_mem[a])) != a % N) m = 1'b1;
`ifdef PLACE_CHECK_EN
    return m;
`else
    return 1'b0;
`endif
  endfunction

  // mode 0: ready always high; 1: random ready; 2: hold first beat off for 20 cycles
  task automatic run_scan(input string tag, input int mode, input bit poke, output int edges_to_done);
    logic [95:0] exp_q[$];
    logic [95:0] obs_q[$];
    logic [95:0] prev_beat = '0;
    bit          pending = 1'b0;
    bit          saw_pos = 1'b0;
    int          hold = 0;
    int          edges = 0;
    for (int a = 0; a < N*N; a++)
      if (grid_mem[a] != -1) exp_q.push_back({32'(grid_mem[a]), 32'(a / N), 32'(a % N)});
    edges_to_done = -1;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (edges < 20000) begin
      @(posedge clk); #1; edges++;
      start = poke && (edges == 40);
      if (rePX || rePY) saw_pos = 1'b1;
      if (edges == 10) check({tag, " busy"}, busy, 1);
      if (pending) check({tag, " stable"}, {out_valid, out_node, out_x, out_y}, {1'b1, prev_beat});
      if (done) begin
        edges_to_done = edges;
        break;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && hold < 20) begin
            out_ready = 1'b0;
            hold++;
          end else out_ready = 1'b1;
        end
      endcase
      prev_beat = {out_node, out_x, out_y};
      if (out_valid && out_ready) begin
        obs_q.push_back(prev_beat);
        pending = 1'b0;
      end else pending = out_valid;
    end
    start = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " beats"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s beat%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, " count"}, count, exp_q.size());
    check({tag, " mismatch"}, mismatch, model_mismatch());
`ifndef PLACE_CHECK_EN
    check({tag, " pos_strobe"}, saw_pos, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check({tag, " sticky"}, {done, mismatch}, {1'b1, model_mismatch()});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ctl"}, {busy, done, out_valid, reGrid, rePX, rePY, mismatch}, 0);
    check({tag, " addr"}, {addrGrid, addrPos, count}, 0);
    check({tag, " beat"}, {out_node, out_x, out_y}, 0);
  endtask

  initial begin
    int t;
`ifdef PLACE_CHECK_EN
    int extra = 3;
`else
    int extra = 0;
`endif
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk); reset = 1'b1;

    // Empty grid: no beats, done 3*N*N+1 edges after the start edge
    run_scan("empty", 0, 1'b0, t);
    check("empty_time", t, 3*N*N + 1);

    // Single consistent node at (2,3); one occupied cell adds 1 cycle (+3 with check)
    clear_mem();
    place(2, 3, 5);
    run_scan("single", 0, 1'b0, t);
    check("single_time", t, 3*N*N + 1 + 1 + extra);

    // First and last corner-ish cells with the first beat held off by backpressure
    clear_mem();
    place(0, 1, 7);
    place(9, 9, 4);
    run_scan("hold", 2, 1'b0, t);

    // Position disagrees with grid; beat still emitted, mismatch sticky until next start
    clear_mem();
    place(4, 4, 6);
    py_mem[6] = 5;
    run_scan("mism", 0, 1'b0, t);
    clear_mem();
    place(1, 2, 3);
    run_scan("mism_clear", 0, 1'b0, t);

    // Randomized grids with random backpressure, one with a start pulse while busy
    for (int r = 0; r < 5; r++) begin
      random_fill();
      run_scan($sformatf("rand%0d", r), 1, (r == 2), t);
    end

    // Reset during the scan of cell 50, then a fresh full scan
    random_fill();
    px_mem[0] = 77;
    place(0, 0, 0);
    px_mem[0] = 77;
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    t = 0;
    while (!(reGrid && addrGrid == 50) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    check("reach_cell50", t < 5000, 1);
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk); reset = 1'b1;
    run_scan("after_reset", 1, 1'b0, t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
